// File: rtl/crc8_frame_arbiter.sv
// Two-requester frame arbiter feeding a bit-serial CRC-8 engine.
// Round-robin at frame granularity; one byte is accepted per 9 cycles.
module crc8_frame_arbiter #(
   parameter logic [7:0] POLY   = 8'h49,
   parameter logic [7:0] INIT   = 8'h00,
   parameter logic [7:0] XOROUT = 8'hFF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic [7:0] byte_data0,
   input  logic [7:0] byte_data1,
   input  logic [1:0] byte_valid,
   input  logic [1:0] byte_last,
   output logic [1:0] byte_ready,
   output logic [1:0] grant,
   output logic [7:0] crc_out,
   output logic       crc_valid,
   output logic       crc_id,
   output logic       frame_abort
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0] state_q, state_d;
   logic [1:0] grant_q, grant_d;
   logic       ptr_q, ptr_d;
   logic [7:0] crc_q, crc_d;
   logic [7:0] shreg_q, shreg_d;
   logic       last_q, last_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] crc_out_q, crc_out_d;
   logic       crc_valid_q, crc_valid_d;
   logic       crc_id_q, crc_id_d;
   logic       abort_q, abort_d;

   logic       gnt_idx;
   logic       winner;
   logic       handshake;
   logic       fb;
   logic [7:0] crc_shift;
   logic [7:0] sel_data;
   logic       sel_last;

   assign gnt_idx    = grant_q[1];
   assign byte_ready = (state_q == ST_WAIT) ? (grant_q & req) : 2'b00;
   assign handshake  = |(byte_valid & byte_ready);
   assign sel_data   = gnt_idx ? byte_data1 : byte_data0;
   assign sel_last   = gnt_idx ? byte_last[1] : byte_last[0];

   // One CRC step, MSB of the shift register is the next message bit.
   assign fb        = crc_q[7] ^ shreg_q[7];
   assign crc_shift = {crc_q[6:0], 1'b0} ^ (fb ? POLY : 8'h00);

   // NOTE: every signal gets a default before the case so no path leaves
   // one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      ptr_d       = ptr_q;
      crc_d       = crc_q;
      shreg_d     = shreg_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      crc_out_d   = crc_out_q;
      crc_valid_d = 1'b0;
      crc_id_d    = crc_id_q;
      abort_d     = 1'b0;
      winner      = ptr_q;

      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               winner  = req[ptr_q] ? ptr_q : ~ptr_q;
               grant_d = winner ? 2'b10 : 2'b01;
               crc_d   = INIT;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!req[gnt_idx]) begin
               abort_d = 1'b1;
               grant_d = 2'b00;
               ptr_d   = ~gnt_idx;
               state_d = ST_IDLE;
            end else if (handshake) begin
               shreg_d = sel_data;
               last_d  = sel_last;
               cnt_d   = 3'd0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            crc_d   = crc_shift;
            shreg_d = {shreg_q[6:0], 1'b0};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               if (last_q) begin
                  // Result registered here so it is presented throughout DONE.
                  crc_out_d   = crc_shift ^ XOROUT;
                  crc_valid_d = 1'b1;
                  crc_id_d    = gnt_idx;
                  state_d     = ST_DONE;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_DONE: begin
            grant_d = 2'b00;
            ptr_d   = ~gnt_idx;
            state_d = ST_IDLE;
         end
         default: begin
            grant_d = 2'b00;
            state_d = ST_IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples its pre-edge inputs regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         grant_q     <= 2'b00;
         ptr_q       <= 1'b0;
         crc_q       <= INIT;
         shreg_q     <= 8'h00;
         last_q      <= 1'b0;
         cnt_q       <= 3'd0;
         crc_out_q   <= 8'h00;
         crc_valid_q <= 1'b0;
         crc_id_q    <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         ptr_q       <= ptr_d;
         crc_q       <= crc_d;
         shreg_q     <= shreg_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         crc_out_q   <= crc_out_d;
         crc_valid_q <= crc_valid_d;
         crc_id_q    <= crc_id_d;
         abort_q     <= abort_d;
      end
   end

   assign grant       = grant_q;
   assign crc_out     = crc_out_q;
   assign crc_valid   = crc_valid_q;
   assign crc_id      = crc_id_q;
   assign frame_abort = abort_q;

endmodule

// File: tb/tb_crc8_frame_arbiter.sv
// Scoreboard bench for crc8_frame_arbiter: drivers push expected CRC results,
// a negedge monitor pops and compares them whenever crc_valid pulses.
module tb_crc8_frame_arbiter;

   logic       clk;
   logic       rst_n;
   logic       r0, r1, v0, v1, l0, l1;
   logic [7:0] d0, d1;
   logic [1:0] req, byte_valid, byte_last;
   logic [1:0] byte_ready, grant;
   logic [7:0] crc_out;
   logic       crc_valid, crc_id, frame_abort;

   assign req        = {r1, r0};
   assign byte_valid = {v1, v0};
   assign byte_last  = {l1, l0};

   crc8_frame_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .byte_data0 (d0),
      .byte_data1 (d1),
      .byte_valid (byte_valid),
      .byte_last  (byte_last),
      .byte_ready (byte_ready),
      .grant      (grant),
      .crc_out    (crc_out),
      .crc_valid  (crc_valid),
      .crc_id     (crc_id),
      .frame_abort(frame_abort)
   );

   typedef struct {
      int         id;
      logic [7:0] crc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   last_hs[2];
   int   n_valid = 0;
   int   aborts_exp = 0;
   int   aborts_seen = 0;
   logic [7:0] held_crc = 8'h00;
   logic prev_valid = 1'b0;
   logic prev_abort = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic set_req(input int id, input logic val);
      if (id == 0) r0 = val;
      else         r1 = val;
   endtask

   task automatic set_byte(input int id, input logic vld, input logic [7:0] dat, input logic lst);
      if (id == 0) begin v0 = vld; d0 = dat; l0 = lst; end
      else         begin v1 = vld; d1 = dat; l1 = lst; end
   endtask

   // Called just after a negedge; returns when byte_ready[id] is seen high.
   task automatic wait_ready(input int id, output bit ok, output int gap);
      ok  = 1'b0;
      gap = 0;
      for (int i = 0; i < 200; i++) begin
         #1;
         if (byte_ready[id]) begin
            ok = 1'b1;
            break;
         end
         gap++;
         @(negedge clk);
      end
      if (!ok) check("ready_timeout", int'(byte_ready[id]), 1);
   endtask

   task automatic send_frame(input int id, input int n, input logic [7:0] b0,
                             input logic [7:0] b1, input logic [7:0] exp_crc, input bit push);
      bit ok;
      int gap;
      if (push) sb.push_back('{id: id, crc: exp_crc});
      set_req(id, 1'b1);
      for (int b = 0; b < n; b++) begin
         set_byte(id, 1'b1, (b == 0) ? b0 : b1, (b == n - 1));
         wait_ready(id, ok, gap);
         if (!ok) begin
            set_byte(id, 1'b0, 8'h00, 1'b0);
            set_req(id, 1'b0);
            return;
         end
         if (b > 0) check("inter_byte_gap", gap, 8);
         last_hs[id] = cyc;
         @(negedge clk);
         set_byte(id, 1'b0, 8'h00, 1'b0);
      end
      set_req(id, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_grant"},       int'(grant), 0);
      check({tag, "_byte_ready"},  int'(byte_ready), 0);
      check({tag, "_crc_out"},     int'(crc_out), 0);
      check({tag, "_crc_valid"},   int'(crc_valid), 0);
      check({tag, "_crc_id"},      int'(crc_id), 0);
      check({tag, "_frame_abort"}, int'(frame_abort), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      held_crc   = 8'h00;
      prev_valid = 1'b0;
      prev_abort = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: protocol invariants every cycle plus scoreboard pops on crc_valid.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check("grant_two_hot", int'(grant == 2'b11), 0);
            check("ready_outside_grant", int'(byte_ready & ~grant), 0);
            if (crc_valid) begin
               check("crc_valid_width", int'(prev_valid), 0);
               if (sb.size() == 0) begin
                  check("unexpected_crc_valid", int'(crc_valid), 0);
               end else begin
                  e = sb.pop_front();
                  check("crc_out", int'(crc_out), int'(e.crc));
                  check("crc_id", int'(crc_id), e.id);
                  check("crc_latency", cyc, last_hs[e.id] + 9);
                  held_crc = e.crc;
                  n_valid++;
               end
            end else begin
               check("crc_out_hold", int'(crc_out), int'(held_crc));
            end
            if (frame_abort) begin
               aborts_seen++;
               check("abort_width", int'(prev_abort), 0);
               check("abort_grant_clear", int'(grant), 0);
            end
            prev_valid = crc_valid;
            prev_abort = frame_abort;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1);
   end

   initial begin
      bit ok;
      int gap;
      rst_n = 1'b0;
      {r0, r1, v0, v1, l0, l1} = '0;
      d0 = 8'h00;
      d1 = 8'h00;
      last_hs[0] = 0;
      last_hs[1] = 0;
      #1;
      check_reset_outputs("por");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Single-byte frames and a two-byte frame with known CRCs.
      send_frame(0, 1, 8'h00, 8'h00, 8'hFF, 1'b1);
      send_frame(1, 1, 8'h01, 8'h00, 8'hB6, 1'b1);
      send_frame(1, 1, 8'h80, 8'h00, 8'hA1, 1'b1);
      send_frame(0, 2, 8'h00, 8'h01, 8'hB6, 1'b1);
      repeat (12) @(negedge clk);

      // Reset in the middle of SHIFT: frame is discarded silently.
      set_req(0, 1'b1);
      set_byte(0, 1'b1, 8'h55, 1'b1);
      wait_ready(0, ok, gap);
      @(negedge clk);
      set_byte(0, 1'b0, 8'h00, 1'b0);
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b0;
      held_crc   = 8'h00;
      prev_valid = 1'b0;
      prev_abort = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      set_req(0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      send_frame(0, 1, 8'h01, 8'h00, 8'hB6, 1'b1);
      repeat (12) @(negedge clk);

      // Both requesters pending from reset: order 0, 1, 0.
      do_reset();
      sb.push_back('{id: 0, crc: 8'hFF});
      sb.push_back('{id: 1, crc: 8'hB6});
      sb.push_back('{id: 0, crc: 8'hA1});
      fork
         begin
            send_frame(0, 1, 8'h00, 8'h00, 8'hFF, 1'b0);
            send_frame(0, 1, 8'h80, 8'h00, 8'hA1, 1'b0);
         end
         send_frame(1, 1, 8'h01, 8'h00, 8'hB6, 1'b0);
      join
      repeat (12) @(negedge clk);

      // Last served was 0, so requester 1 is granted; it withdraws -> abort,
      // then requester 0 is served.
      r0 = 1'b1;
      r1 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (grant != 2'b00) break;
         @(negedge clk);
      end
      check("abort_setup_grant", int'(grant), 2);
      aborts_exp++;
      set_req(1, 1'b0);
      send_frame(0, 1, 8'h00, 8'h00, 8'hFF, 1'b1);
      repeat (15) @(negedge clk);

      check("sb_drained", sb.size(), 0);
      check("crc_valid_count", n_valid, 9);
      check("abort_count", aborts_seen, aborts_exp);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
